water_fill_ctrl: RTL
====================

# water_fill_ctrl

Parametrised water-level selector and fill/drain sequencer for the washing-machine controller. It holds the user-selected water level and steps it with the select button while the machine is powered and not started. On start it opens the inlet valve until the level sensor reaches the selection, holds the level, then drains on request. It flags a fault when a fill or drain exceeds its timeout, and sits between the front-panel logic and the valve drivers.

## Interface
- LVL_W, 4, width of level values (kg units)
- LVL_MIN, 2, lowest selectable level
- LVL_MAX, 5, highest selectable level; select wraps to LVL_MIN after this
- LVL_DEF, 2, level loaded at reset, power-off and drain completion
- FILL_TO, 600, fill timeout in `tick` strobes
- DRAIN_TO, 400, drain timeout in `tick` strobes
- clk  in  1  system clock, all logic on posedge
- reset  in  1  reset, synchronous, active-low
- power_on  in  1  power LED state, synchronised level
- start  in  1  start LED state, synchronised level
- sel_btn  in  1  level-select button, synchronised and debounced level
- drain_req  in  1  one-cycle pulse from the wash sequencer: wash finished, drain now
- tick  in  1  one-cycle timebase strobe for the timeout counter
- level_meas  in  LVL_W  measured water level from the sensor
- level_sel  out  LVL_W  currently selected target level
- valve_in  out  1  inlet valve open
- valve_out  out  1  drain valve open
- fill_done  out  1  one-cycle pulse when the target level is reached
- fault  out  1  timeout fault, sticky until power-off
- state  out  3  FSM state code, for display and debug

## Operation
- States: IDLE, FILL, HOLD, DRAIN, FAULT.
- Global override: `reset`=0 or `power_on`=0 forces IDLE, `level_sel`=LVL_DEF, both valves off, `fault`=0, timer=0. Both take priority over every transition below.
- IDLE
  - On a rising edge of `sel_btn` while `start`=0: `level_sel` increments; LVL_MAX wraps to LVL_MIN.
  - On a rising edge of `start`: go to FILL and clear the timer. Edges are detected against the registered previous value.
- FILL
  - `valve_in`=1.
  - If `level_meas` >= `level_sel`: go to HOLD and pulse `fill_done`.
  - Otherwise the timer increments on each `tick`. When it reaches FILL_TO: go to FAULT.
- HOLD
  - Valves off.
  - `drain_req` goes to DRAIN and clears the timer.
- DRAIN
  - `valve_out`=1.
  - `level_meas`==0 goes to IDLE and loads `level_sel`=LVL_DEF.
  - Timer reaching DRAIN_TO goes to FAULT.
- FAULT: valves off, `fault`=1. The only exit is the power-off override.
- `sel_btn` edges outside IDLE, or while `start`=1, are ignored; `level_sel` is frozen during a cycle.
- Simultaneous events:
  - A `start` edge and a `sel_btn` edge in the same cycle: start wins and the level is unchanged.
  - In FILL, if the level is reached in the same cycle the timeout would fire, the level wins and the block goes to HOLD.
- `drain_req` outside HOLD is ignored.
- Illegal state encodings recover to IDLE.
- `valve_in` and `valve_out` are never 1 together.

## Timing
- All outputs are registered.
- Reset values: `level_sel`=LVL_DEF, `valve_in`=0, `valve_out`=0, `fill_done`=0, `fault`=0, `state`=IDLE.
- `sel_btn` rising edge sampled at cycle N: `level_sel` updates at N+1.
- `start` edge at N: `state`=FILL and `valve_in`=1 at N+1.
- Sensor match at N: `valve_in`=0 and a single-cycle `fill_done` at N+1.
- Timeout: FAULT is entered in the cycle after the FILL_TO-th (or DRAIN_TO-th) `tick`.
- Timer width is $clog2(max(FILL_TO,DRAIN_TO)+1). It saturates and never wraps.
- Elaboration asserts LVL_MIN <= LVL_DEF <= LVL_MAX < 2**LVL_W.

## Structure
- Package `washer_pkg` holds:
  - the state enum (IDLE=0, FILL=1, HOLD=2, DRAIN=3, FAULT=4)
  - the default level and timeout constants, shared with the wash sequencer.
- Sub-module `rise_edge`: one-flop rising-edge detector with synchronous active-low `reset`. Instantiated for `sel_btn` and `start`.

## Test plan
- Reset and step the level:
  - Stimulus: reset, `power_on`=1, `start`=0, five `sel_btn` presses.
  - Required: `level_sel` goes 2→3→4→5→2→3.
- Normal cycle:
  - Stimulus: `start` edge with `level_sel`=4, `level_meas` ramps 0..4.
  - Required: `valve_in`=1 until `level_meas`=4, then a single `fill_done` pulse and HOLD.
- Drain:
  - Stimulus: `drain_req` in HOLD, then `level_meas` falls to 0.
  - Required: `valve_out`=1, then IDLE with `level_sel`=2.
- Fill timeout:
  - Stimulus: FILL_TO=8, `level_meas` held at 0, 8 ticks.
  - Required: FAULT, `fault`=1, valves 0, select presses ignored.
- Power-off mid-fill:
  - Stimulus: `power_on`=0 during FILL.
  - Required: next cycle IDLE, `valve_in`=0, `level_sel`=2, `fault` cleared.
- Simultaneous edges:
  - Stimulus: `start` and `sel_btn` rising in the same cycle.
  - Required: FILL entered with `level_sel` unchanged.

Source files
------------

// File: rtl/water_fill_ctrl_pkg.sv
// Shared washer definitions: FSM state codes, default level and timeouts.
// The wash sequencer imports the same constants so both blocks agree.
package washer_pkg;

  localparam int STATE_W    = 3;
  localparam int LVL_W_C    = 4;
  localparam int LVL_MIN_C  = 2;
  localparam int LVL_MAX_C  = 5;
  localparam int LVL_DEF_C  = 2;
  localparam int FILL_TO_C  = 600;
  localparam int DRAIN_TO_C = 400;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    FAULT = 3'd4
  } state_e;

  // Larger of two integers, used to size the shared timeout timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/water_fill_ctrl_if.sv
// Signal bundle between front panel / sensor side and the fill controller.
// There is no valid/ready handshake here: every input is a synchronised
// level sampled each clock, except drain_req and tick which are one-cycle
// strobes; every output is a registered level, except fill_done which is a
// one-cycle registered pulse.
interface water_fill_ctrl_if
  import washer_pkg::*;
#(
  parameter int LVL_W = LVL_W_C
);
  logic               power_on;
  logic               start;
  logic               sel_btn;
  logic               drain_req;
  logic               tick;
  logic [LVL_W-1:0]   level_meas;
  logic [LVL_W-1:0]   level_sel;
  logic               valve_in;
  logic               valve_out;
  logic               fill_done;
  logic               fault;
  logic [STATE_W-1:0] state;

  // Front panel, sensor and timebase side.
  modport master (
    output power_on, start, sel_btn, drain_req, tick, level_meas,
    input  level_sel, valve_in, valve_out, fill_done, fault, state
  );

  // Fill controller side.
  modport slave (
    input  power_on, start, sel_btn, drain_req, tick, level_meas,
    output level_sel, valve_in, valve_out, fill_done, fault, state
  );
endinterface

// File: rtl/water_fill_ctrl_rise_edge.sv
// One-flop rising-edge detector; the output is combinational from the
// current input and the registered previous value.
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);
  logic prev_q;

  // Remember last cycle's value of the input.
  always_ff @(posedge clk) begin
    if (!reset) prev_q <= 1'b0;
    else        prev_q <= sig_i;
  end

  assign rise_o = sig_i & ~prev_q;
endmodule

// File: rtl/water_fill_ctrl.sv
// Water-level selector and fill/hold/drain sequencer with timeout fault.
// Power-off acts like a reset for everything except the edge detectors.
module water_fill_ctrl
  import washer_pkg::*;
#(
  parameter int LVL_W    = LVL_W_C,
  parameter int LVL_MIN  = LVL_MIN_C,
  parameter int LVL_MAX  = LVL_MAX_C,
  parameter int LVL_DEF  = LVL_DEF_C,
  parameter int FILL_TO  = FILL_TO_C,
  parameter int DRAIN_TO = DRAIN_TO_C
) (
  input logic               clk,
  input logic               reset,
  water_fill_ctrl_if.slave  bus
);

  localparam int TW = $clog2(max_int(FILL_TO, DRAIN_TO) + 1);

  localparam logic [TW-1:0]    TIMER_MAX  = TW'(max_int(FILL_TO, DRAIN_TO));
  localparam logic [TW-1:0]    FILL_TO_T  = TW'(FILL_TO);
  localparam logic [TW-1:0]    DRAIN_TO_T = TW'(DRAIN_TO);
  localparam logic [LVL_W-1:0] LVL_MIN_T  = LVL_W'(LVL_MIN);
  localparam logic [LVL_W-1:0] LVL_MAX_T  = LVL_W'(LVL_MAX);
  localparam logic [LVL_W-1:0] LVL_DEF_T  = LVL_W'(LVL_DEF);

  // Reject level parameters that cannot be represented or ordered.
  if (!((LVL_MIN <= LVL_DEF) && (LVL_DEF <= LVL_MAX) &&
        (LVL_MAX < (2 ** LVL_W)))) begin : g_bad_levels
    $error("water_fill_ctrl: level parameters out of order or range");
  end

  state_e           state_q, state_d;
  logic [LVL_W-1:0] level_sel_q, level_sel_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             valve_in_q, valve_in_d;
  logic             valve_out_q, valve_out_d;
  logic             fill_done_q, fill_done_d;
  logic             fault_q, fault_d;

  logic             sel_rise;
  logic             start_rise;
  logic [TW-1:0]    timer_inc;
  logic [LVL_W-1:0] level_next;

  rise_edge u_sel_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (bus.sel_btn),
    .rise_o (sel_rise)
  );

  rise_edge u_start_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (bus.start),
    .rise_o (start_rise)
  );

  // Saturating timer step and wrapping level step.
  assign timer_inc  = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
  assign level_next = (level_sel_q >= LVL_MAX_T) ? LVL_MIN_T
                                                  : level_sel_q + 1'b1;

  // Next state, level, timer and registered-output values.
  always_comb begin
    state_d     = state_q;
    level_sel_d = level_sel_q;
    timer_d     = timer_q;
    fill_done_d = 1'b0;

    if (!bus.power_on) begin
      state_d     = IDLE;
      level_sel_d = LVL_DEF_T;
      timer_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A start edge beats a simultaneous select edge.
          if (start_rise) begin
            state_d = FILL;
            timer_d = '0;
          end else if (sel_rise && !bus.start) begin
            level_sel_d = level_next;
          end
        end
        FILL: begin
          // Reaching the level beats a timeout in the same cycle.
          if (bus.level_meas >= level_sel_q) begin
            state_d     = HOLD;
            fill_done_d = 1'b1;
          end else if (bus.tick) begin
            timer_d = timer_inc;
            if (timer_inc >= FILL_TO_T) state_d = FAULT;
          end
        end
        HOLD: begin
          if (bus.drain_req) begin
            state_d = DRAIN;
            timer_d = '0;
          end
        end
        DRAIN: begin
          if (bus.level_meas == '0) begin
            state_d     = IDLE;
            level_sel_d = LVL_DEF_T;
          end else if (bus.tick) begin
            timer_d = timer_inc;
            if (timer_inc >= DRAIN_TO_T) state_d = FAULT;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end

    // Outputs follow the next state so they are registered alongside it;
    // the two valves are decoded from distinct states and cannot overlap.
    valve_in_d  = (state_d == FILL);
    valve_out_d = (state_d == DRAIN);
    fault_d     = (state_d == FAULT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      level_sel_q <= LVL_DEF_T;
      timer_q     <= '0;
      valve_in_q  <= 1'b0;
      valve_out_q <= 1'b0;
      fill_done_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_sel_q <= level_sel_d;
      timer_q     <= timer_d;
      valve_in_q  <= valve_in_d;
      valve_out_q <= valve_out_d;
      fill_done_q <= fill_done_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.level_sel = level_sel_q;
  assign bus.valve_in  = valve_in_q;
  assign bus.valve_out = valve_out_q;
  assign bus.fill_done = fill_done_q;
  assign bus.fault     = fault_q;
  assign bus.state     = state_q;

endmodule
